// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding scoreboard.
// Slot entries are sized for the widest supported register address.
package pipeline_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int DEPTH_DEF    = 3;
  localparam int LOAD_RDY_DEF = 2;
  localparam int AW_MAX       = 8;
  localparam int FWD_RF       = 0;

  typedef struct packed {
    logic              v;
    logic [AW_MAX-1:0] dst;
    logic              we;
    logic              ld;
  } slot_t;

  // First slot whose forward bus carries this producer's result.
  function automatic int rdy_slot(
    input logic ld,
    input int   load_rdy
  );
    return ld ? load_rdy : 1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Looks up one source operand against the in-flight slots.
// Reports the youngest live producer and whether its data is forwardable.
module sb_match
  import pipeline_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_RDY = LOAD_RDY_DEF,
  parameter int LAST     = DEPTH - 1,
  parameter int OFF      = 0,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  slot_t [DEPTH-1:0] slots_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              rdy_o
);

  logic ld_hit;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    ld_hit = 1'b0;
    if (used_i && (src_i != '0)) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if ((s <= LAST) &&
            slots_i[s].v && slots_i[s].we &&
            (slots_i[s].dst == AW_MAX'(src_i))) begin
          hit_o  = 1'b1;
          idx_o  = SEL_W'(s);
          ld_hit = slots_i[s].ld;
        end
      end
    end
  end

  // OFF shifts the lookup to where the producer sits at consume time.
  assign rdy_o = (int'(idx_o) + OFF) >= rdy_slot(ld_hit, LOAD_RDY);

endmodule

// File: rtl/pipeline_scoreboard.sv
// Stateful hazard/forwarding unit for the in-order pipeline.
// Tracks in-flight destinations and drives stall plus ID/EX forward selects.
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_RDY = LOAD_RDY_DEF,
  parameter int SEL_W    = $clog2(DEPTH),
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_we,
  input  logic                      id_is_load,
  input  logic                      id_is_branch,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue,
  output logic [NUM_SRC*SEL_W-1:0]  id_br_sel,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [DEPTH-1:0]          slot_valid,
  output logic [CNT_W-1:0]          stall_cnt
);

  slot_t [DEPTH-1:0] slot_q, slot_d;

  logic [NUM_SRC-1:0] ex_hit, ex_rdy;
  logic [NUM_SRC-1:0] br_hit, br_rdy;
  logic [NUM_SRC-1:0] haz;

  logic [NUM_SRC-1:0][SEL_W-1:0] ex_idx;
  logic [NUM_SRC-1:0][SEL_W-1:0] br_idx;

  logic [NUM_SRC*SEL_W-1:0] sel_d, sel_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sb_match #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .LOAD_RDY (LOAD_RDY),
      .LAST     (DEPTH - 2),
      .OFF      (1),
      .SEL_W    (SEL_W)
    ) u_ex (
      .slots_i (slot_q),
      .src_i   (id_src[i*REG_AW +: REG_AW]),
      .used_i  (id_src_used[i] & ~id_is_branch),
      .hit_o   (ex_hit[i]),
      .idx_o   (ex_idx[i]),
      .rdy_o   (ex_rdy[i])
    );

    sb_match #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .LOAD_RDY (LOAD_RDY),
      .LAST     (DEPTH - 1),
      .OFF      (0),
      .SEL_W    (SEL_W)
    ) u_br (
      .slots_i (slot_q),
      .src_i   (id_src[i*REG_AW +: REG_AW]),
      .used_i  (id_src_used[i] & id_is_branch),
      .hit_o   (br_hit[i]),
      .idx_o   (br_idx[i]),
      .rdy_o   (br_rdy[i])
    );

    assign haz[i] = (ex_hit[i] & ~ex_rdy[i])
                  | (br_hit[i] & ~br_rdy[i]);

    assign id_br_sel[i*SEL_W +: SEL_W] =
      (br_hit[i] & br_rdy[i]) ? br_idx[i]
                              : SEL_W'(FWD_RF);

    // By EX time the producer has moved one slot further on.
    assign sel_d[i*SEL_W +: SEL_W] =
      !issue    ? SEL_W'(FWD_RF) :
      ex_hit[i] ? ex_idx[i] + SEL_W'(1) :
                  SEL_W'(FWD_RF);
  end

  assign stall = id_valid & ~flush & (|haz);
  assign issue = id_valid & ~flush & ~stall;

  always_comb begin
    slot_d = '0;
    if (issue) begin
      slot_d[0].v   = 1'b1;
      slot_d[0].dst = AW_MAX'(id_dst);
      slot_d[0].we  = id_we & (id_dst != '0);
      slot_d[0].ld  = id_is_load;
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      slot_d[k+1] = slot_q[k];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_vld
    assign slot_valid[k] = slot_q[k].v;
  end

  assign ex_fwd_sel = sel_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard; expected EX selects
// are queued at drive time and checked after the clock edge.
module tb_pipeline_scoreboard;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int D  = 3;
  localparam int SW = 2;
  localparam int CW = 6;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]    id_src_used;
  logic [AW-1:0]    id_dst;
  logic             id_we;
  logic             id_is_load;
  logic             id_is_branch;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [NS*SW-1:0] id_br_sel;
  logic [NS*SW-1:0] ex_fwd_sel;
  logic [D-1:0]     slot_valid;
  logic [CW-1:0]    stall_cnt;

  int total = 0;
  int bad = 0;
  logic [CW-1:0]    exp_cnt;
  logic [NS*SW-1:0] exq[$];

  pipeline_scoreboard #(
    .REG_AW   (AW),
    .NUM_SRC  (NS),
    .DEPTH    (D),
    .LOAD_RDY (2),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dst       (id_dst),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .id_is_branch (id_is_branch),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .id_br_sel    (id_br_sel),
    .ex_fwd_sel   (ex_fwd_sel),
    .slot_valid   (slot_valid),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input string       what,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s obs=%0h exp=%0h",
             tag, what, obs, expv);
    end
  endtask

  task automatic drive(
    input int v, input int s0, input int s1,
    input int u, input int dst, input int we,
    input int ld, input int br, input int fl
  );
    id_valid     = v[0];
    id_src       = {s1[AW-1:0], s0[AW-1:0]};
    id_src_used  = u[NS-1:0];
    id_dst       = dst[AW-1:0];
    id_we        = we[0];
    id_is_load   = ld[0];
    id_is_branch = br[0];
    flush        = fl[0];
  endtask

  task automatic step(
    input string tag,
    input int v, input int s0, input int s1,
    input int u, input int dst, input int we,
    input int ld, input int br, input int fl,
    input int es, input int b0, input int b1,
    input int x0, input int x1
  );
    logic [NS*SW-1:0] e;
    drive(v, s0, s1, u, dst, we, ld, br, fl);
    #1;
    chk(tag, "stall", stall, es);
    chk(tag, "issue", issue,
        v[0] & ~es[0] & ~fl[0]);
    chk(tag, "br_sel", id_br_sel,
        {b1[SW-1:0], b0[SW-1:0]});
    exq.push_back({x1[SW-1:0], x0[SW-1:0]});
    if (es[0] && (exp_cnt != '1)) exp_cnt++;
    @(posedge clk);
    #1;
    e = exq.pop_front();
    chk(tag, "ex_sel", ex_fwd_sel, e);
    chk(tag, "cnt", stall_cnt, exp_cnt);
  endtask

  task automatic idle3();
    for (int k = 0; k < 3; k++) begin
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,
           0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    exp_cnt = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst", "slot_v", slot_valid, 0);
    chk("rst", "cnt", stall_cnt, 0);
    chk("rst", "ex_sel", ex_fwd_sel, 0);
    chk("rst", "stall", stall, 0);
    chk("rst", "br_sel", id_br_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU -> ALU: no stall, forward from MEM
    step("alu1", 1, 2, 3, 3, 1, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("alu2", 1, 1, 5, 3, 4, 1, 0, 0, 0,
         0, 0, 0, 1, 0);
    idle3();

    // load-use: one stall, then forward from WB
    step("lw3", 1, 2, 0, 1, 3, 1, 1, 0, 0,
         0, 0, 0, 0, 0);
    step("use_s", 1, 3, 3, 3, 4, 1, 0, 0, 0,
         1, 0, 0, 0, 0);
    step("use", 1, 3, 3, 3, 4, 1, 0, 0, 0,
         0, 0, 0, 2, 2);
    idle3();

    // branch after ALU: one stall, br_sel 1
    step("add5", 1, 1, 2, 3, 5, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("beq_s", 1, 5, 0, 3, 0, 0, 0, 1, 0,
         1, 0, 0, 0, 0);
    step("beq", 1, 5, 0, 3, 0, 0, 0, 1, 0,
         0, 1, 0, 0, 0);
    idle3();

    // branch after load: two stalls, br_sel 2
    step("lw5", 1, 1, 0, 1, 5, 1, 1, 0, 0,
         0, 0, 0, 0, 0);
    step("lbeq_s1", 1, 5, 0, 3, 0, 0, 0, 1, 0,
         1, 0, 0, 0, 0);
    step("lbeq_s2", 1, 5, 0, 3, 0, 0, 0, 1, 0,
         1, 0, 0, 0, 0);
    step("lbeq", 1, 5, 0, 3, 0, 0, 0, 1, 0,
         0, 2, 0, 0, 0);
    idle3();

    // r0 never produces; unused sources never match
    step("add_r0", 1, 1, 2, 3, 0, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("rd_r0", 1, 0, 0, 3, 6, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("lw9", 1, 1, 0, 1, 9, 1, 1, 0, 0,
         0, 0, 0, 0, 0);
    step("unused", 1, 9, 9, 0, 10, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    idle3();

    // youngest producer wins
    step("r7a", 1, 1, 1, 3, 7, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("r7b", 1, 2, 2, 3, 7, 1, 0, 0, 0,
         0, 0, 0, 0, 0);
    step("r8", 1, 7, 3, 3, 8, 1, 0, 0, 0,
         0, 0, 0, 1, 0);
    idle3();

    // flush beats a pending load-use hazard
    step("lw3b", 1, 2, 0, 1, 3, 1, 1, 0, 0,
         0, 0, 0, 0, 0);
    step("flush", 1, 3, 3, 3, 4, 1, 0, 0, 1,
         0, 0, 0, 0, 0);
    step("aft_fl", 1, 3, 3, 3, 4, 1, 0, 0, 0,
         0, 0, 0, 2, 2);
    chk("aft_fl", "slot_v", slot_valid, 3'b101);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    drive(1, 4, 4, 3, 11, 1, 0, 0, 0);
    #1;
    chk("mid_rst", "slot_v", slot_valid, 0);
    chk("mid_rst", "cnt", stall_cnt, 0);
    chk("mid_rst", "ex_sel", ex_fwd_sel, 0);
    chk("mid_rst", "stall", stall, 0);
    chk("mid_rst", "br_sel", id_br_sel, 0);
    exp_cnt = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // chained load-use to saturate the counter
    step("sat_lw", 1, 1, 0, 1, 5, 1, 1, 0, 0,
         0, 0, 0, 0, 0);
    for (int n = 0; n < (1 << CW) + 5; n++) begin
      step("sat_s", 1, 5, 0, 1, 5, 1, 1, 0, 0,
           1, 0, 0, 0, 0);
      step("sat_i", 1, 5, 0, 1, 5, 1, 1, 0, 0,
           0, 0, 0, 2, 0);
    end
    chk("sat", "cnt", stall_cnt, {CW{1'b1}});
    idle3();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised hazard/forwarding scoreboard for the in-order MIPS pipeline.
- Replaces the separate forwarding and hazard-detection blocks with one stateful unit.
- Tracks destination tags of every in-flight instruction in a DEPTH-slot shift register (slot 0 = EX … slot DEPTH-1 = WB).
- Generates the ID-stage stall, ID-stage branch-operand forwarding selects, and registered EX-stage ALU forwarding selects, for NUM_SRC source operands and a configurable load latency.

Parameters:
- REG_AW, 5: register address width; register 0 is hardwired zero.
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 3: tracked slots after ID; minimum 2.
- LOAD_RDY, 2: first slot whose forward bus carries load data; range 1..DEPTH-1.
- SEL_W, $clog2(DEPTH): forward-select width (derived).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_src  in  NUM_SRC*REG_AW  source register numbers; operand i at [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_dst  in  REG_AW  destination register
- id_we  in  1  instruction writes id_dst
- id_is_load  in  1  result comes from memory
- id_is_branch  in  1  operands are compared in ID
- flush  in  1  kill the instruction in ID
- stall  out  1  hold PC and IF/ID; insert bubble
- issue  out  1  id_valid & ~stall & ~flush
- id_br_sel  out  NUM_SRC*SEL_W  ID forward select: 0 = register file, s = slot-s forward bus
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered EX forward select, same encoding
- slot_valid  out  DEPTH  occupancy per slot, for debug
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot entry fields: v, dst, we, ld.
- Every posedge, slot[k+1] <= slot[k] for k = 0..DEPTH-2, and slot[DEPTH-1] drops out.
- slot[0] <= {1, id_dst, id_we & (id_dst != 0), id_is_load} when issue; otherwise a bubble (v = 0, we = 0).
- Live producer: v & we.
- Slot s has ready(s) = 1 if s >= (ld ? LOAD_RDY : 1).
- Register-file writes at slot DEPTH-1 are not write-through. Slot DEPTH-1 is therefore forwardable; a producer that has retired is read from the register file.
- EX operand i (non-branch, used, src != 0), evaluated in ID:
  - At EX time a producer now in slot s sits in slot s+1.
  - Youngest match is the smallest s <= DEPTH-2 with matching dst.
  - If ready(s+1) is 0, raise a hazard.
  - Otherwise the next ex_fwd_sel[i] = s+1.
  - With no match, next ex_fwd_sel[i] = 0.
- Branch operand i (id_is_branch, used, src != 0):
  - Youngest match is the smallest s <= DEPTH-1.
  - If ready(s) is 0, raise a hazard; slot 0 is never ready for a branch.
  - Otherwise id_br_sel[i] = s, combinational.
  - With no match, id_br_sel[i] = 0.
  - For non-branch instructions id_br_sel = 0.
- stall = id_valid & ~flush & (any hazard). Stall is combinational from registered slots and ID inputs.
- ex_fwd_sel register:
  - Loads the computed selects on issue.
  - Loads 0 on a stall, flush or invalid cycle (bubble).
- Operand rules:
  - Source 0, or id_src_used[i] = 0, never matches and never stalls.
  - Destination 0 never creates a producer.
- Simultaneous flush and hazard: flush wins; stall = 0, bubble inserted, stall_cnt unchanged.
- stall_cnt increments on every stall cycle and saturates at all-ones.
- Reset, asynchronous and usable mid-operation:
  - All slots invalid; ex_fwd_sel = 0; stall_cnt = 0.
  - Consequently stall = 0, id_br_sel = 0 and slot_valid = 0 immediately.
- Stall latency: a dependent ALU consumer after an ALU producer has zero stalls (default parameters).
- Load-use (LOAD_RDY = 2) stall is 1 cycle.
- Branch after ALU stalls 1 cycle; branch after load stalls 2 cycles.

Decomposition:
- Package pipeline_pkg:
  - slot_t struct {v, dst, we, ld}.
  - Constants FWD_RF = 0 and default REG_AW/DEPTH/LOAD_RDY.
- Sub-module sb_match: one operand versus the slot array. Outputs hit, youngest slot index and ready. It is instantiated 2*NUM_SRC times: EX lookahead and branch lookups.

Test Plan:
- add r1 ← r2,r3 issued, then add r4 ← r1,r5 → stall = 0 throughout. The cycle the second add is in EX: ex_fwd_sel[0] = 1, ex_fwd_sel[1] = 0.
- lw r3, then add r4 ← r3,r3 → stall = 1 for exactly 1 cycle, stall_cnt = 1. Next cycle ex_fwd_sel = {2,2}.
- add r5, then beq r5,r0 → 1 stall cycle, then id_br_sel[0] = 1 (producer in MEM). With lw r5 instead → 2 stall cycles, then id_br_sel[0] = 2.
- add r0 ← r1,r2, then add r6 ← r0,r0; separately id_src_used = 0 on a matching source → no stall, all selects 0.
- add r7 = 1, add r7 = 2, then add r8 ← r7 → the younger producer is chosen: ex_fwd_sel[0] = 1, not 2.
- flush asserted with a pending load-use hazard → stall = 0, bubble inserted. rst_n low mid-stream → slot_valid = 0 and stall_cnt = 0 with no clock edge.
- Forced 2^CNT_W + 5 stall cycles → stall_cnt holds at all-ones.
